// File: rtl/pe_out_chan.sv
// PE output channel: reservation-ordered result FIFO whose head entry is multicast
// to NUM_DST destinations. An entry retires once every enabled destination has accepted it.
module pe_out_chan #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_DST    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [NUM_DST-1:0]    dst_mask,
    input  logic                  fu_alloc,
    output logic                  alloc_rdy,
    input  logic                  fu_valid,
    input  logic [DATA_WIDTH-1:0] fu_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_DST-1:0]    out_valid,
    input  logic [NUM_DST-1:0]    out_ready,
    output logic                  empty,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         fill_ptr_reg, fill_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [DEPTH-1:0]      filled_reg, filled_next;
    logic [NUM_DST-1:0]    sent_reg, sent_next;
    logic                  err_reg, err_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         count;
    logic [PW-1:0]         outstanding;
    logic [AW-1:0]         rd_idx, fill_idx;
    logic                  alloc_fire, fill_fire, head_ok, retire;
    logic [NUM_DST-1:0]    acc;

    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign alloc_rdy   = (count < PW'(DEPTH));
    assign alloc_fire  = fu_alloc && alloc_rdy;
    // A reservation made this cycle may be filled in the same cycle.
    assign outstanding = (wr_ptr_reg - fill_ptr_reg) + {{(PW-1){1'b0}}, alloc_fire};
    assign fill_fire   = fu_valid && (outstanding != '0);
    assign rd_idx      = rd_ptr_reg[AW-1:0];
    assign fill_idx    = fill_ptr_reg[AW-1:0];

    assign head_ok   = (count != '0) && filled_reg[rd_idx];
    assign out_valid = {NUM_DST{head_ok}} & dst_mask & ~sent_reg;
    assign acc       = out_valid & out_ready;
    assign retire    = head_ok && (((sent_reg | acc) & dst_mask) == dst_mask);
    assign out_data  = mem[rd_idx];
    assign empty     = (count == '0);
    assign err       = err_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        fill_ptr_next = fill_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        filled_next   = filled_reg;
        sent_next     = sent_reg | acc;
        err_next      = err_reg;
        if (retire) begin
            rd_ptr_next         = rd_ptr_reg + 1'b1;
            filled_next[rd_idx] = 1'b0;
            sent_next           = '0;
        end
        if (alloc_fire)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (fill_fire) begin
            fill_ptr_next         = fill_ptr_reg + 1'b1;
            filled_next[fill_idx] = 1'b1;
        end
        if (fu_valid && !fill_fire)
            err_next = 1'b1;
        // Flush wins over everything else this cycle, but the error flag survives it.
        if (clear) begin
            wr_ptr_next   = '0;
            fill_ptr_next = '0;
            rd_ptr_next   = '0;
            filled_next   = '0;
            sent_next     = '0;
            err_next      = err_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            fill_ptr_reg <= '0;
            rd_ptr_reg   <= '0;
            filled_reg   <= '0;
            sent_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            fill_ptr_reg <= fill_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            filled_reg   <= filled_next;
            sent_reg     <= sent_next;
            err_reg      <= err_next;
        end
    end

    // Slots are reset so the head data reads as zero straight after reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst)
                mem[gi] <= '0;
            else if (fill_fire && !clear && (fill_idx == AW'(gi)))
                mem[gi] <= fu_out;
        end
    end
endmodule
